apb_master_arb: RTL

- APB3 master that shares the peripheral APB bus between two requesters: req0 (core/host side) and req1 (DMA/test side).
- Round-robin arbitration between requesters.
- Address decode to the 2-bit PSEL (bit0 = GPIO slave, bit1 = UART slave).
- Sequences the SETUP/ACCESS phases, honours PREADY wait states, enforces a timeout, and returns PRDATA/PSLVERR to the granted requester.
- Sits between the system-side requesters and the GPIO_APB/UART APB slaves.

---
 rtl/apb_master_pkg.sv | 40 ++++
 rtl/apb_master_arb_rr.sv | 43 ++++
 rtl/apb_master_arb.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types, select encodings and address decode for the APB master arbiter.
package apb_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAGE_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [1:0] PSEL_NONE = 2'b00;
  localparam logic [1:0] PSEL_GPIO = 2'b01;
  localparam logic [1:0] PSEL_UART = 2'b10;

  // Request payload as presented by either requester.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  // Map the 4 KiB page of an address onto a one-hot slave select.
  function automatic logic [1:0] apb_decode(input logic [ADDR_W-1:0] addr,
                                            input logic [PAGE_W-1:0] base0,
                                            input logic [PAGE_W-1:0] base1);
    logic [1:0] sel;
    sel = PSEL_NONE;
    if (addr[ADDR_W-1:ADDR_W-PAGE_W] == base0) begin
      sel = PSEL_GPIO;
    end else if (addr[ADDR_W-1:ADDR_W-PAGE_W] == base1) begin
      sel = PSEL_UART;
    end
    return sel;
  endfunction

endpackage

// File: rtl/apb_master_arb_rr.sv
// Two-requester round-robin arbiter; the pointer flips to the other side on every accept.
module apb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant_c,
  output logic       grant_idx_c,
  output logic       accept_c
);

  logic ptr_q;
  logic ptr_d;

  // Pick the sole requester, or the pointer's favourite on conflict.
  always_comb begin
    grant_idx_c = 1'b0;
    if (valid == 2'b11) begin
      grant_idx_c = ptr_q;
    end else if (valid[1]) begin
      grant_idx_c = 1'b1;
    end
    accept_c = en & (|valid);
    grant_c  = 2'b00;
    if (accept_c) begin
      grant_c = grant_idx_c ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (accept_c) begin
      ptr_d = ~grant_idx_c;
    end
  end

  // Priority pointer register; 0 favours req0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB3 master shared by two requesters: round-robin grant, page decode, wait states and timeout.
module apb_master_arb
  import apb_master_pkg::*;
#(
  parameter logic [19:0]  SLV0_BASE = 20'h40000,
  parameter logic [19:0]  SLV1_BASE = 20'h40001,
  parameter int unsigned  TIMEOUT   = 16,
  parameter logic [2:0]   PROT_VAL  = 3'b000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic [1:0]  PSEL,
  output logic        PENABLE,
  output logic [2:0]  PPROT,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  apb_state_e        state_q, state_d;
  logic              idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [1:0]        psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              rsp0_q, rsp0_d;
  logic              rsp1_q, rsp1_d;

  logic              arb_en_c;
  logic [1:0]        grant_c;
  logic              gidx_c;
  logic              accept_c;
  apb_req_t          req_in_c;
  logic [1:0]        dec_c;

  assign arb_en_c = (state_q == ST_IDLE);

  apb_rr_arb2 u_arb (
    .clk         (PCLK),
    .rst_n       (PRESETn),
    .en          (arb_en_c),
    .valid       ({req1_valid, req0_valid}),
    .grant_c     (grant_c),
    .grant_idx_c (gidx_c),
    .accept_c    (accept_c)
  );

  // Ready is a same-cycle grant so the requester sees acceptance at the sampling edge.
  assign req0_ready = grant_c[0];
  assign req1_ready = grant_c[1];

  // Payload of whichever requester is being granted, and its slave decode.
  always_comb begin
    req_in_c = '{write: req0_write, addr: req0_addr, wdata: req0_wdata};
    if (gidx_c) begin
      req_in_c = '{write: req1_write, addr: req1_addr, wdata: req1_wdata};
    end
    dec_c = apb_decode(req_in_c.addr, SLV0_BASE, SLV1_BASE);
  end

  // Next-state and registered-output logic for the SETUP/ACCESS sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    rsp0_d    = 1'b0;
    rsp1_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          idx_d = gidx_c;
          if (dec_c != PSEL_NONE) begin
            state_d   = ST_SETUP;
            paddr_d   = req_in_c.addr;
            pwdata_d  = req_in_c.wdata;
            pwrite_d  = req_in_c.write;
            psel_d    = dec_c;
            penable_d = 1'b0;
          end else begin
            // Unmapped address: answer with an error without driving the bus.
            state_d = ST_RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
            rsp0_d  = ~gidx_c;
            rsp1_d  = gidx_c;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          state_d   = ST_RESP;
          rdata_d   = pwrite_q ? 32'h0 : PRDATA;
          err_d     = PSLVERR;
          psel_d    = PSEL_NONE;
          penable_d = 1'b0;
          cnt_d     = '0;
          rsp0_d    = ~idx_q;
          rsp1_d    = idx_q;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th ACCESS cycle without PREADY: abort.
          state_d   = ST_RESP;
          rdata_d   = 32'h0;
          err_d     = 1'b1;
          psel_d    = PSEL_NONE;
          penable_d = 1'b0;
          cnt_d     = '0;
          rsp0_d    = ~idx_q;
          rsp1_d    = idx_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = PSEL_NONE;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      idx_q     <= 1'b0;
      cnt_q     <= '0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      pwrite_q  <= 1'b0;
      psel_q    <= PSEL_NONE;
      penable_q <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      rsp0_q    <= rsp0_d;
      rsp1_q    <= rsp1_d;
    end
  end

  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PWRITE     = pwrite_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PPROT      = PROT_VAL;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;

endmodule
